// File: rtl/apb_mem_slave_wait.sv
// APB slave fronting a word-addressed memory array, with separate wait-state
// counts for reads and writes. Writes merge bytes under pstrb_i. Addresses at
// or above DEPTH return an error response and never touch the memory.
module apb_mem_slave_wait #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 768,
    parameter int RD_WAIT = 0,
    parameter int WR_WAIT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                psel_i,
    input  logic                penable_i,
    input  logic [ADDR_W-1:0]   paddr_i,
    input  logic                pwrite_i,
    input  logic [DATA_W-1:0]   pwdata_i,
    input  logic [DATA_W/8-1:0] pstrb_i,
    output logic [DATA_W-1:0]   prdata_o,
    output logic                pready_o,
    output logic                pslverr_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0] RD_N = 4'(RD_WAIT);
    localparam logic [3:0] WR_N = 4'(WR_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READY
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic                err_q, err_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic [DATA_W-1:0]   prdata_q, prdata_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                setupErr;
    logic [3:0]          setupN;
    logic [ADDR_W-1:0]   rdAddr;
    logic [DATA_W-1:0]   rdWord;
    logic                memWrEn;

    // Decode the transfer being presented and fetch the word it will read
    always_comb begin
        setupErr = ({1'b0, paddr_i} >= DEPTH_L);
        setupN   = pwrite_i ? WR_N : RD_N;
        rdAddr   = (state_q == ST_IDLE) ? paddr_i : addr_q;
        rdWord   = mem[rdAddr];
        memWrEn  = (state_q == ST_READY) && write_q && !err_q && !reset;
    end

    // Next-state and registered-output logic for the transfer FSM
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        err_d     = err_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (psel_i && !penable_i) begin
                    addr_d  = paddr_i;
                    write_d = pwrite_i;
                    err_d   = setupErr;
                    if (setupN == 4'd0) begin
                        state_d   = ST_READY;
                        pready_d  = 1'b1;
                        pslverr_d = setupErr;
                        prdata_d  = (!pwrite_i && !setupErr) ? rdWord : '0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = setupN;
                    end
                end
            end
            ST_WAIT: begin
                if (!psel_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (penable_i) begin
                    if (cnt_q == 4'd1) begin
                        state_d   = ST_READY;
                        cnt_d     = 4'd0;
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                        prdata_d  = (!write_q && !err_q) ? rdWord : '0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            ST_READY: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any transfer in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            err_q     <= err_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    // Commit a write as its completion cycle ends, merging only strobed bytes
    always_ff @(posedge clk) begin
        if (memWrEn) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (pstrb_i[b]) begin
                    mem[addr_q][8*b +: 8] <= pwdata_i[8*b +: 8];
                end
            end
        end
    end

    assign prdata_o  = prdata_q;
    assign pready_o  = pready_q;
    assign pslverr_o = pslverr_q;

endmodule

// File: tb/tb_apb_mem_slave_wait.sv
// Bench for apb_mem_slave_wait. Two instances share one APB bus: A has one
// write wait state, B has three. A transaction-level model predicts, cycle by
// cycle, when the selected instance must complete and with what response.
module tb_apb_mem_slave_wait;

    localparam int DEPTH = 768;
    localparam int RD_W  = 0;
    localparam int WR_A  = 1;
    localparam int WR_B  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic [9:0]  paddr = '0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    int          tgt = 0;

    logic        pselA, pselB;
    logic [31:0] prdataA, prdataB;
    logic        preadyA, preadyB, pslverrA, pslverrB;

    logic        chkEn = 1'b0;
    logic        expReady = 1'b0;
    logic        expErr = 1'b0;
    logic        expRdValid = 1'b0;
    logic [31:0] expData = '0;

    logic [31:0] modelMem [2][1024];
    bit          used [1024];
    logic [9:0]  rndAddr [10];
    logic [31:0] rdExp;

    int checks = 0;
    int errors = 0;

    assign pselA = psel && (tgt == 0);
    assign pselB = psel && (tgt == 1);

    apb_mem_slave_wait #(.RD_WAIT(RD_W), .WR_WAIT(WR_A)) dutA (
        .clk(clk), .reset(reset), .psel_i(pselA), .penable_i(penable),
        .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .prdata_o(prdataA), .pready_o(preadyA), .pslverr_o(pslverrA)
    );

    apb_mem_slave_wait #(.RD_WAIT(RD_W), .WR_WAIT(WR_B)) dutB (
        .clk(clk), .reset(reset), .psel_i(pselB), .penable_i(penable),
        .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .prdata_o(prdataB), .pready_o(preadyB), .pslverr_o(pslverrB)
    );

    always #5 clk = ~clk;

    // Compare the selected instance against the model's expectation for this cycle
    task automatic checkOutput();
        logic        r, e;
        logic [31:0] d;
        r = (tgt == 0) ? preadyA : preadyB;
        e = (tgt == 0) ? pslverrA : pslverrB;
        d = (tgt == 0) ? prdataA : prdataB;
        checks++;
        if (r !== expReady) begin
            errors++;
            $display("[TB] FAIL pready t=%0t dut=%0d got=%b want=%b", $time, tgt, r, expReady);
        end
        if (expReady) begin
            checks++;
            if (e !== expErr) begin
                errors++;
                $display("[TB] FAIL pslverr t=%0t dut=%0d got=%b want=%b", $time, tgt, e, expErr);
            end
            if (expRdValid) begin
                checks++;
                if (d !== expData) begin
                    errors++;
                    $display("[TB] FAIL prdata t=%0t dut=%0d got=%h want=%h", $time, tgt, d, expData);
                end
            end
        end else begin
            checks++;
            if (e !== 1'b0) begin
                errors++;
                $display("[TB] FAIL pslverr_idle t=%0t dut=%0d got=%b want=0", $time, tgt, e);
            end
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("[TB] FAIL prdata_idle t=%0t dut=%0d got=%h want=0", $time, tgt, d);
            end
        end
    endtask

    always @(negedge clk) begin
        if (chkEn) checkOutput();
    end

    // Pin a model prediction to a hand-computed value
    task automatic pinModel(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL model_%s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic clearExp();
        expReady   = 1'b0;
        expErr     = 1'b0;
        expRdValid = 1'b0;
        expData    = '0;
    endtask

    task automatic idleCycle();
        @(posedge clk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        clearExp();
    endtask

    // One full APB transfer; abortAt>=0 drops psel after that many ACCESS cycles
    task automatic applyStimulus(input int t, input logic wr, input logic [9:0] a,
                                 input logic [31:0] d, input logic [3:0] s,
                                 input int abortAt, output logic [31:0] rdVal);
        int   n;
        logic err;
        n   = wr ? ((t == 0) ? WR_A : WR_B) : RD_W;
        err = (int'(a) >= DEPTH);
        rdVal = err ? 32'h0 : modelMem[t][a];
        @(posedge clk); #1;
        tgt     = t;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        pstrb   = s;
        clearExp();
        for (int k = 1; k <= n + 1; k++) begin
            @(posedge clk); #1;
            clearExp();
            if (abortAt >= 0 && k == abortAt + 1) begin
                psel    = 1'b0;
                penable = 1'b0;
                return;
            end
            penable = 1'b1;
            if (k == n + 1) begin
                expReady   = 1'b1;
                expErr     = err;
                expRdValid = !wr;
                expData    = rdVal;
                if (wr && !err) begin
                    for (int b = 0; b < 4; b++)
                        if (s[b]) modelMem[t][a][8*b +: 8] = d[8*b +: 8];
                end
            end
        end
    endtask

    initial begin
        logic [31:0] dummy;
        for (int i = 0; i < 1024; i++) begin
            modelMem[0][i] = '0;
            modelMem[1][i] = '0;
            used[i] = 1'b0;
        end

        // Reset held two cycles, outputs idle on both instances
        @(posedge clk); #1;
        tgt = 0; chkEn = 1'b1; clearExp();
        @(posedge clk); #1;
        tgt = 1;
        @(posedge clk); #1;
        reset = 1'b0; tgt = 0;

        // Full-word write then read-back, back to back
        applyStimulus(0, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF, -1, dummy);
        applyStimulus(0, 1'b0, 10'h005, 32'h0, 4'h0, -1, rdExp);
        pinModel("rd005", rdExp, 32'hDEADBEEF);

        // Partial byte-strobe write over a known word
        applyStimulus(0, 1'b1, 10'h010, 32'hAABBCCDD, 4'hF, -1, dummy);
        applyStimulus(0, 1'b1, 10'h010, 32'h11223344, 4'b0101, -1, dummy);
        applyStimulus(0, 1'b1, 10'h010, 32'h99999999, 4'b0000, -1, dummy);
        applyStimulus(0, 1'b0, 10'h010, 32'h0, 4'hF, -1, rdExp);
        pinModel("rd010", rdExp, 32'hAA22CC44);

        // Out-of-range accesses and the last valid word
        applyStimulus(0, 1'b1, 10'h2FF, 32'hCAFEF00D, 4'hF, -1, dummy);
        applyStimulus(0, 1'b1, 10'h300, 32'h12345678, 4'hF, -1, dummy);
        applyStimulus(0, 1'b0, 10'h300, 32'h0, 4'h0, -1, rdExp);
        pinModel("rd300", rdExp, 32'h0);
        applyStimulus(0, 1'b0, 10'h2FF, 32'h0, 4'h0, -1, rdExp);
        pinModel("rd2FF", rdExp, 32'hCAFEF00D);

        // penable high in idle must not start a transfer
        @(posedge clk); #1;
        tgt = 0; psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 10'h005;
        clearExp();
        idleCycle();
        idleCycle();

        // Abort on the three-wait-state instance leaves memory untouched
        applyStimulus(1, 1'b1, 10'h020, 32'h13579BDF, 4'hF, -1, dummy);
        applyStimulus(1, 1'b1, 10'h020, 32'h0000FFFF, 4'hF, 1, dummy);
        idleCycle();
        applyStimulus(1, 1'b0, 10'h020, 32'h0, 4'h0, -1, rdExp);
        pinModel("rd020", rdExp, 32'h13579BDF);

        // Ten random back-to-back writes followed by ten reads
        for (int i = 0; i < 10; i++) begin
            logic [9:0] a;
            do a = 10'($urandom_range(32'h040, 32'h0FF)); while (used[a]);
            used[a] = 1'b1;
            rndAddr[i] = a;
            applyStimulus(0, 1'b1, a, $urandom, 4'hF, -1, dummy);
        end
        for (int i = 0; i < 10; i++)
            applyStimulus(0, 1'b0, rndAddr[i], 32'h0, 4'h0, -1, rdExp);

        // Reset during a write's wait state: no completion, no memory change
        @(posedge clk); #1;
        tgt = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 10'h2FF; pwdata = 32'h0BADF00D; pstrb = 4'hF;
        clearExp();
        @(posedge clk); #1;
        penable = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; psel = 1'b0; penable = 1'b0;
        applyStimulus(0, 1'b0, 10'h2FF, 32'h0, 4'h0, -1, rdExp);
        pinModel("rd2FF_after_reset", rdExp, 32'hCAFEF00D);

        // Reset during a read's setup: pready stays low next cycle
        @(posedge clk); #1;
        tgt = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = rndAddr[0];
        reset = 1'b1;
        clearExp();
        @(posedge clk); #1;
        reset = 1'b0; psel = 1'b0; penable = 1'b0;
        idleCycle();

        @(posedge clk); #1;
        chkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
